l2_arbiter: RTL and testbench
=============================

# l2_arbiter

Two-port arbiter sharing the single L2 cache port between the L1 instruction cache (read-only) and the L1 data cache (read/write). It sits between the split L1 caches and the L2 and sequences one full 128-bit line transaction at a time. It holds each grant until the L2 responds, and routes the response and line data back to the granted requester only.

## Interface
- Parameters: none. Widths come from `lc3b_types`: `lc3b_word` is 16 bits, `lc3b_line` is 128 bits.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; forces the idle state and zeroes all registered outputs.
- `i_mem_read` in 1: I-cache line read request, level, held until `i_mem_resp`.
- `i_mem_address` in 16: I-cache line address.
- `i_mem_rdata` out 128: line data to the I-cache.
- `i_mem_resp` out 1: one-cycle completion pulse to the I-cache.
- `d_mem_read` in 1: D-cache line read request, level.
- `d_mem_write` in 1: D-cache line writeback request, level; never asserted together with `d_mem_read`.
- `d_mem_address` in 16: D-cache line address.
- `d_mem_wdata` in 128: writeback line.
- `d_mem_rdata` out 128: line data to the D-cache.
- `d_mem_resp` out 1: one-cycle completion pulse to the D-cache.
- `l2_mem_read` out 1: read request to the L2, registered.
- `l2_mem_write` out 1: write request to the L2, registered.
- `l2_mem_address` out 16: registered, line-aligned (bits [3:0] = 0).
- `l2_mem_wdata` out 128: registered writeback line.
- `l2_mem_rdata` in 128: line returned by the L2.
- `l2_mem_resp` in 1: L2 completion pulse.

## Operation
- States: `ARB_IDLE`, `ARB_I` (serving I-cache), `ARB_D` (serving D-cache).
- In `ARB_IDLE`, if either cache requests, the arbiter picks a winner per Configuration.
  - It captures the winner's address, with [3:0] forced to 0, plus its wdata and read/write kind into the L2 output registers.
  - It then moves to `ARB_I` or `ARB_D`.
- In `ARB_I`/`ARB_D`, the L2 outputs are held constant. On `l2_mem_resp`:
  - The granted requester's `*_mem_resp` is driven combinationally equal to `l2_mem_resp`.
  - `l2_mem_rdata` is forwarded to the granted requester's `*_rdata`.
  - The L2 request registers clear, and the state returns to `ARB_IDLE`.
- The non-granted requester's resp is always 0, and its rdata is always 0.
- Requesters must hold their request until they see resp. A request withdrawn mid-service is a protocol violation and is flagged by a simulation assertion. The arbiter ignores the withdrawal and finishes the L2 transaction.
- Reset values: state `ARB_IDLE`; `l2_mem_read`=0, `l2_mem_write`=0, `l2_mem_address`=0, `l2_mem_wdata`=0; `i_mem_resp`=0, `d_mem_resp`=0; both rdata outputs 0; round-robin pointer favors the D-cache.
- Reset mid-transaction abandons the transaction. L2 outputs drop immediately (asynchronously). The L2 must accept a dropped request.

## Timing
- Request first high in cycle N while idle: the L2 request is visible in cycle N+1.
- `l2_mem_resp` in cycle M: the requester's resp is asserted in cycle M (zero added latency on return). The arbiter is idle in M+1.
- Back-to-back: if the other cache is waiting, its L2 request is visible at M+2. Minimum gap between L2 transactions is one idle cycle.
- Simultaneous requests in the same idle cycle are resolved per Configuration. The loser waits and is granted at the next idle evaluation.
- An `l2_mem_resp` seen while idle is ignored; it causes no resp to either cache and no state change.

## Configuration
- `L2_ARB_ROUND_ROBIN_EN` defined:
  - A one-bit last-granted pointer updates at every grant.
  - On a simultaneous request, the cache not served last wins.
  - Neither cache waits more than one transaction.
- Not defined:
  - Fixed priority, D-cache always wins ties.
  - The pointer register is not built.

## Structure
- Add to `lc3b_types`:
  - `lc3b_arb_state` enum (`ARB_IDLE`, `ARB_I`, `ARB_D`).
  - `lc3b_line_align_mask` constant, 16'hFFF0.
- One sub-module: `l2_arb_select`.
  - Combinational; takes both request levels and the pointer; outputs grant_i/grant_d, one-hot or none.
  - It isolates the policy that the macro changes.

## Test plan
- Single I-read:
  - Stimulus: `i_mem_read`=1, address 16'h1234.
  - Response: `l2_mem_read`=1 with address 16'h1230 next cycle.
  - L2 resp with rdata 128'hA5…A5 gives `i_mem_resp`=1 and the same rdata in the same cycle; `d_mem_resp` stays 0.
- D-write:
  - Stimulus: `d_mem_write`, address 16'h8000, wdata 128'h0123….
  - Response: `l2_mem_write`=1 with matching address and wdata, held constant across 10 wait cycles.
  - `d_mem_resp` is pulsed exactly once.
- Simultaneous I-read and D-read from reset:
  - The D-cache is served first; the I-cache's L2 request appears 2 cycles after the D-cache's resp.
  - With `L2_ARB_ROUND_ROBIN_EN`, a repeat collision then serves the I-cache first. Without it, the D-cache wins again.
- Reset asserted mid-`ARB_D`:
  - All L2 outputs read 0 within the same cycle; the state is `ARB_IDLE`.
  - A pending I-read is granted one cycle after reset deasserts.
- Stray `l2_mem_resp` while idle: no resp to either cache, no state change.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b widths and L2 arbiter types.
// Used by l2_arbiter and l2_arb_select.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_I,
    ARB_D
  } lc3b_arb_state;

  localparam lc3b_word lc3b_line_align_mask = 16'hFFF0;

  function automatic lc3b_word line_align(input lc3b_word a);
    return a & lc3b_line_align_mask;
  endfunction

endpackage

// File: rtl/l2_arb_select.sv
// Grant policy between I-cache and D-cache requests.
// favor_d breaks ties; one-hot or no grant out.
module l2_arb_select (
  input  logic i_req,
  input  logic d_req,
  input  logic favor_d,
  output logic grant_i,
  output logic grant_d
);

  always_comb begin
    grant_i = i_req & (~d_req | ~favor_d);
    grant_d = d_req & (~i_req | favor_d);
  end

endmodule

// File: rtl/l2_arbiter.sv
// Shares one L2 port between split L1 I/D caches.
// L2_ARB_ROUND_ROBIN_EN: round-robin ties, else D wins.
module l2_arbiter
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     i_mem_read,
  input  lc3b_word i_mem_address,
  output lc3b_line i_mem_rdata,
  output logic     i_mem_resp,
  input  logic     d_mem_read,
  input  logic     d_mem_write,
  input  lc3b_word d_mem_address,
  input  lc3b_line d_mem_wdata,
  output lc3b_line d_mem_rdata,
  output logic     d_mem_resp,
  output logic     l2_mem_read,
  output logic     l2_mem_write,
  output lc3b_word l2_mem_address,
  output lc3b_line l2_mem_wdata,
  input  lc3b_line l2_mem_rdata,
  input  logic     l2_mem_resp
);

  lc3b_arb_state state;
  lc3b_arb_state state_next;
  logic          d_req;
  logic          favor_d;
  logic          grant_i;
  logic          grant_d;
  logic          idle;

  assign d_req = d_mem_read | d_mem_write;
  assign idle  = (state == ARB_IDLE);

`ifdef L2_ARB_ROUND_ROBIN_EN
  // Points at the cache that should win the next tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      favor_d <= 1'b1;
    end else if (idle) begin
      if (grant_d)
        favor_d <= 1'b0;
      else if (grant_i)
        favor_d <= 1'b1;
    end
  end
`else
  assign favor_d = 1'b1;
`endif

  l2_arb_select u_select (
    .i_req   (i_mem_read),
    .d_req   (d_req),
    .favor_d (favor_d),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      ARB_IDLE: begin
        if (grant_d)
          state_next = ARB_D;
        else if (grant_i)
          state_next = ARB_I;
      end
      ARB_I, ARB_D: begin
        if (l2_mem_resp)
          state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ARB_IDLE;
      l2_mem_read    <= 1'b0;
      l2_mem_write   <= 1'b0;
      l2_mem_address <= '0;
      l2_mem_wdata   <= '0;
    end else begin
      state <= state_next;
      if (idle) begin
        if (grant_d) begin
          l2_mem_read    <= d_mem_read;
          l2_mem_write   <= d_mem_write;
          l2_mem_address <= line_align(d_mem_address);
          l2_mem_wdata   <= d_mem_wdata;
        end else if (grant_i) begin
          l2_mem_read    <= 1'b1;
          l2_mem_write   <= 1'b0;
          l2_mem_address <= line_align(i_mem_address);
          l2_mem_wdata   <= '0;
        end
      end else if (l2_mem_resp) begin
        l2_mem_read    <= 1'b0;
        l2_mem_write   <= 1'b0;
        l2_mem_address <= '0;
        l2_mem_wdata   <= '0;
      end
    end
  end

  // Zero-latency return path; a stray resp while idle reaches nobody.
  always_comb begin
    i_mem_resp  = (state == ARB_I) & l2_mem_resp;
    d_mem_resp  = (state == ARB_D) & l2_mem_resp;
    i_mem_rdata = i_mem_resp ? l2_mem_rdata : '0;
    d_mem_rdata = d_mem_resp ? l2_mem_rdata : '0;
  end

  a_i_hold: assert property (
    @(posedge clk) disable iff (reset)
    (state == ARB_I) |-> i_mem_read);

  a_d_hold: assert property (
    @(posedge clk) disable iff (reset)
    (state == ARB_D) |-> d_req);

  a_d_kind: assert property (
    @(posedge clk) disable iff (reset)
    !(d_mem_read && d_mem_write));

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: vector table, scoreboard queue,
// collision, reset and stray-response sequences.
module tb_l2_arbiter;
  import lc3b_types::*;

  logic     clk = 1'b0;
  logic     reset;
  logic     i_mem_read;
  lc3b_word i_mem_address;
  lc3b_line i_mem_rdata;
  logic     i_mem_resp;
  logic     d_mem_read;
  logic     d_mem_write;
  lc3b_word d_mem_address;
  lc3b_line d_mem_wdata;
  lc3b_line d_mem_rdata;
  logic     d_mem_resp;
  logic     l2_mem_read;
  logic     l2_mem_write;
  lc3b_word l2_mem_address;
  lc3b_line l2_mem_wdata;
  lc3b_line l2_mem_rdata;
  logic     l2_mem_resp;

  always #5 clk = ~clk;

  l2_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .i_mem_read     (i_mem_read),
    .i_mem_address  (i_mem_address),
    .i_mem_rdata    (i_mem_rdata),
    .i_mem_resp     (i_mem_resp),
    .d_mem_read     (d_mem_read),
    .d_mem_write    (d_mem_write),
    .d_mem_address  (d_mem_address),
    .d_mem_wdata    (d_mem_wdata),
    .d_mem_rdata    (d_mem_rdata),
    .d_mem_resp     (d_mem_resp),
    .l2_mem_read    (l2_mem_read),
    .l2_mem_write   (l2_mem_write),
    .l2_mem_address (l2_mem_address),
    .l2_mem_wdata   (l2_mem_wdata),
    .l2_mem_rdata   (l2_mem_rdata),
    .l2_mem_resp    (l2_mem_resp)
  );

  typedef struct {
    bit          is_d;
    bit          wr;
    logic [15:0] addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    int          lat;
    logic [15:0] exp_addr;
  } vec_t;

  typedef struct {
    bit          is_d;
    bit          wr;
    logic [15:0] exp_addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
  } exp_t;

  exp_t q[$];
  vec_t vecs[4];
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [127:0] got,
                     input logic [127:0] want);
    total++;
    if (got === want)
      passed++;
    else
      $display("FAIL %s: got %h required %h", name, got, want);
  endtask

  task automatic fail(input string name);
    total++;
    $display("FAIL %s: no DUT response within bound", name);
  endtask

  task automatic drive(input bit is_d, input bit wr,
                       input logic [15:0] addr,
                       input logic [127:0] wdata,
                       input logic [127:0] rdata,
                       input logic [15:0] exp_addr);
    exp_t e;
    if (is_d) begin
      d_mem_read    = !wr;
      d_mem_write   = wr;
      d_mem_address = addr;
      d_mem_wdata   = wdata;
    end else begin
      i_mem_read    = 1'b1;
      i_mem_address = addr;
    end
    e.is_d     = is_d;
    e.wr       = wr;
    e.exp_addr = exp_addr;
    e.wdata    = wdata;
    e.rdata    = rdata;
    q.push_back(e);
  endtask

  task automatic serve(input int lat, input int exp_wait);
    exp_t e;
    int   n;
    bit   held;
    n    = 0;
    held = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!(l2_mem_read | l2_mem_write) && n < 8);
    chk("grant_latency", 128'(n), 128'(exp_wait));
    if (q.size() == 0) begin
      fail("scoreboard_empty");
      return;
    end
    e = q.pop_front();
    if (!(l2_mem_read | l2_mem_write)) begin
      fail("l2_request_timeout");
      return;
    end
    chk("l2_read", 128'(l2_mem_read), 128'(!e.wr));
    chk("l2_write", 128'(l2_mem_write), 128'(e.wr));
    chk("l2_addr", 128'(l2_mem_address), 128'(e.exp_addr));
    if (e.wr)
      chk("l2_wdata", l2_mem_wdata, e.wdata);
    repeat (lat) begin
      @(negedge clk);
      if (l2_mem_read !== !e.wr || l2_mem_write !== e.wr)
        held = 1'b0;
      if (l2_mem_address !== e.exp_addr)
        held = 1'b0;
      if (e.wr && l2_mem_wdata !== e.wdata)
        held = 1'b0;
      if (i_mem_resp | d_mem_resp)
        held = 1'b0;
    end
    chk("l2_hold", 128'(held), 128'(1));
    l2_mem_resp  = 1'b1;
    l2_mem_rdata = e.rdata;
    #1;
    if (e.is_d) begin
      chk("d_resp", 128'(d_mem_resp), 128'(1));
      chk("d_rdata", d_mem_rdata, e.rdata);
      chk("i_resp_idle", 128'(i_mem_resp), 128'(0));
      chk("i_rdata_zero", i_mem_rdata, '0);
    end else begin
      chk("i_resp", 128'(i_mem_resp), 128'(1));
      chk("i_rdata", i_mem_rdata, e.rdata);
      chk("d_resp_idle", 128'(d_mem_resp), 128'(0));
      chk("d_rdata_zero", d_mem_rdata, '0);
    end
    @(negedge clk);
    l2_mem_resp  = 1'b0;
    l2_mem_rdata = '0;
    if (e.is_d) begin
      d_mem_read  = 1'b0;
      d_mem_write = 1'b0;
    end else begin
      i_mem_read = 1'b0;
    end
    #1;
    chk("resp_single_pulse", 128'(i_mem_resp | d_mem_resp), 128'(0));
    chk("l2_clear", 128'({l2_mem_read, l2_mem_write}), 128'(0));
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    i_mem_read    = 1'b0;
    i_mem_address = '0;
    d_mem_read    = 1'b0;
    d_mem_write   = 1'b0;
    d_mem_address = '0;
    d_mem_wdata   = '0;
    l2_mem_rdata  = '0;
    l2_mem_resp   = 1'b0;
    q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 0, 16'h1234, '0, {16{8'hA5}}, 2, 16'h1230};
    vecs[1] = '{1, 1, 16'h8000,
                128'h0123456789ABCDEF0FEDCBA987654321,
                {16{8'h3C}}, 10, 16'h8000};
    vecs[2] = '{1, 0, 16'h4567, '0,
                128'hDEADBEEF00112233445566778899AABB, 0, 16'h4560};
    vecs[3] = '{0, 0, 16'hFFFF, '0,
                128'hFEEDFACE0000FFFF1234567887654321, 3, 16'hFFF0};

    // Reset values
    reset = 1'b1;
    i_mem_read = 1'b0; i_mem_address = '0;
    d_mem_read = 1'b0; d_mem_write = 1'b0;
    d_mem_address = '0; d_mem_wdata = '0;
    l2_mem_rdata = '0; l2_mem_resp = 1'b0;
    @(negedge clk);
    chk("rst_l2_read", 128'(l2_mem_read), 128'(0));
    chk("rst_l2_write", 128'(l2_mem_write), 128'(0));
    chk("rst_l2_addr", 128'(l2_mem_address), 128'(0));
    chk("rst_l2_wdata", l2_mem_wdata, '0);
    chk("rst_i_resp", 128'(i_mem_resp), 128'(0));
    chk("rst_d_resp", 128'(d_mem_resp), 128'(0));
    chk("rst_i_rdata", i_mem_rdata, '0);
    chk("rst_d_rdata", d_mem_rdata, '0);
    chk("rst_state", 128'(dut.state == ARB_IDLE), 128'(1));
    @(negedge clk);
    reset = 1'b0;

    // Single transactions from the table
    for (int k = 0; k < 4; k++) begin
      drive(vecs[k].is_d, vecs[k].wr, vecs[k].addr,
            vecs[k].wdata, vecs[k].rdata, vecs[k].exp_addr);
      serve(vecs[k].lat, 1);
    end

    // Stray L2 response while idle
    l2_mem_resp  = 1'b1;
    l2_mem_rdata = {8{16'hC0DE}};
    #1;
    chk("stray_i_resp", 128'(i_mem_resp), 128'(0));
    chk("stray_d_resp", 128'(d_mem_resp), 128'(0));
    chk("stray_i_rdata", i_mem_rdata, '0);
    chk("stray_d_rdata", d_mem_rdata, '0);
    @(negedge clk);
    l2_mem_resp  = 1'b0;
    l2_mem_rdata = '0;
    #1;
    chk("stray_state", 128'(dut.state == ARB_IDLE), 128'(1));
    chk("stray_l2_idle", 128'({l2_mem_read, l2_mem_write}), 128'(0));

    // Collision from reset: D first, I two cycles after D resp
    do_reset();
    drive(1, 0, 16'h2004, '0, {4{32'h11112222}}, 16'h2000);
    drive(0, 0, 16'h1000, '0, {4{32'h33334444}}, 16'h1000);
    serve(2, 1);
    serve(1, 1);

    // Collision, then D re-requests right after its resp
    do_reset();
    drive(1, 0, 16'h5008, '0, {4{32'h55556666}}, 16'h5000);
    i_mem_read    = 1'b1;
    i_mem_address = 16'h3000;
    serve(1, 1);
    d_mem_read    = 1'b1;
    d_mem_address = 16'h600C;
`ifdef L2_ARB_ROUND_ROBIN_EN
    drive(0, 0, 16'h3000, '0, {4{32'h77778888}}, 16'h3000);
    drive(1, 0, 16'h600C, '0, {4{32'h9999AAAA}}, 16'h6000);
`else
    drive(1, 0, 16'h600C, '0, {4{32'h9999AAAA}}, 16'h6000);
    drive(0, 0, 16'h3000, '0, {4{32'h77778888}}, 16'h3000);
`endif
    serve(1, 1);
    serve(1, 1);

    // Reset in the middle of a D writeback with an I-read pending
    do_reset();
    d_mem_write   = 1'b1;
    d_mem_address = 16'hABCD;
    d_mem_wdata   = {8{16'hBEEF}};
    @(negedge clk);
    chk("midrst_pre_write", 128'(l2_mem_write), 128'(1));
    chk("midrst_pre_addr", 128'(l2_mem_address), 128'(16'hABC0));
    i_mem_read    = 1'b1;
    i_mem_address = 16'h7777;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_l2_read", 128'(l2_mem_read), 128'(0));
    chk("midrst_l2_write", 128'(l2_mem_write), 128'(0));
    chk("midrst_l2_addr", 128'(l2_mem_address), 128'(0));
    chk("midrst_l2_wdata", l2_mem_wdata, '0);
    chk("midrst_state", 128'(dut.state == ARB_IDLE), 128'(1));
    d_mem_write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    drive(0, 0, 16'h7777, '0, {4{32'hABCDEF01}}, 16'h7770);
    serve(0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
